// File: rtl/utf16_pkg.sv
// Shared constants and byte-ordering helper for the UTF-16 byte serializer.
// Optional feature macro: UTF16_BOM_EN (prefix a byte-order mark after reset).
package utf16_pkg;

  localparam logic [20:0] REPLACEMENT_CHAR = 21'h00FFFD;
  localparam logic [15:0] BOM              = 16'hFEFF;
  localparam logic [15:0] SURR_HI_BASE     = 16'hD800;
  localparam logic [15:0] SURR_LO_BASE     = 16'hDC00;
  localparam logic [20:0] SUPP_BASE        = 21'h010000;
  localparam logic [20:0] MAX_CP           = 21'h10FFFF;
  localparam logic [20:0] SURR_MIN         = 21'h00D800;
  localparam logic [20:0] SURR_MAX         = 21'h00DFFF;

  // Returns a 16-bit unit with its two bytes in emission order (first byte in [15:8]).
  function automatic logic [15:0] order_unit(input logic [15:0] unit, input logic le);
    return le ? {unit[7:0], unit[15:8]} : unit;
  endfunction

endpackage

// File: rtl/utf16_unit_split.sv
// Combinational split of a code point into one or two UTF-16 code units,
// substituting U+FFFD for surrogates and values beyond U+10FFFF.
module utf16_unit_split
  import utf16_pkg::*;
(
  input  logic [20:0] cp_i,
  output logic        subst_o,
  output logic [15:0] u0_o,
  output logic [15:0] u1_o,
  output logic [1:0]  units_o
);

  logic [20:0] cpEff;
  logic [19:0] suppOffset;

  // Legality check, substitution and surrogate-pair construction
  always_comb begin
    subst_o    = ((cp_i >= SURR_MIN) && (cp_i <= SURR_MAX)) || (cp_i > MAX_CP);
    cpEff      = subst_o ? REPLACEMENT_CHAR : cp_i;
    suppOffset = 20'(cpEff - SUPP_BASE);
    u0_o       = cpEff[15:0];
    u1_o       = 16'h0000;
    units_o    = 2'd1;
    if (cpEff >= SUPP_BASE) begin
      u0_o    = SURR_HI_BASE | {6'b0, suppOffset[19:10]};
      u1_o    = SURR_LO_BASE | {6'b0, suppOffset[9:0]};
      units_o = 2'd2;
    end
  end

endmodule

// File: rtl/utf16_byte_serializer.sv
// UTF-16 byte serializer: one code point in, its UTF-16 bytes out one per handshake.
// The head of a byte shift register is the output byte; a remaining-byte count
// stands in for the state machine. Optional macro UTF16_BOM_EN prefixes the
// first character after reset with a byte-order mark.
module utf16_byte_serializer
  import utf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] cp_in,
  input  logic        cp_valid,
  output logic        cp_ready,
  input  logic        little_endian,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        replaced,
  output logic        busy
);

`ifdef UTF16_BOM_EN
  localparam int SR_W = 48;
`else
  localparam int SR_W = 32;
`endif

  logic [SR_W-1:0] shreg_q, shreg_d;
  logic [2:0]      count_q, count_d;
  logic            replaced_q, replaced_d;
`ifdef UTF16_BOM_EN
  logic            bomPending_q, bomPending_d;
`endif

  logic        accept;
  logic        subst;
  logic [15:0] unit0, unit1;
  logic [1:0]  units;
  logic [31:0] charBytes;
  logic [2:0]  charCount;

  utf16_unit_split uSplit (
    .cp_i    (cp_in),
    .subst_o (subst),
    .u0_o    (unit0),
    .u1_o    (unit1),
    .units_o (units)
  );

  assign cp_ready   = (count_q == 3'd0) || ((count_q == 3'd1) && byte_ready);
  assign accept     = cp_valid && cp_ready;
  assign byte_valid = (count_q != 3'd0);
  assign busy       = (count_q != 3'd0);
  assign byte_out   = shreg_q[SR_W-1 -: 8];
  assign replaced   = replaced_q;

  // Byte images of the incoming character in the byte order sampled on accept
  always_comb begin
    charBytes = {order_unit(unit0, little_endian), order_unit(unit1, little_endian)};
    charCount = (units == 2'd2) ? 3'd4 : 3'd2;
  end

  // Next state: a new character load takes priority over a plain shift, which
  // lets the final byte of one character and the next accept share a cycle
  always_comb begin
    shreg_d    = shreg_q;
    count_d    = count_q;
    replaced_d = 1'b0;
`ifdef UTF16_BOM_EN
    bomPending_d = bomPending_q;
`endif
    if (accept) begin
      replaced_d = subst;
`ifdef UTF16_BOM_EN
      if (bomPending_q) begin
        shreg_d      = {order_unit(BOM, little_endian), charBytes};
        count_d      = charCount + 3'd2;
        bomPending_d = 1'b0;
      end else begin
        shreg_d = {charBytes, 16'h0000};
        count_d = charCount;
      end
`else
      shreg_d = charBytes;
      count_d = charCount;
`endif
    end else if (byte_valid && byte_ready) begin
      shreg_d = {shreg_q[SR_W-9:0], 8'h00};
      count_d = count_q - 3'd1;
    end
  end

  // State registers; reset drops any pending bytes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      count_q    <= 3'd0;
      replaced_q <= 1'b0;
`ifdef UTF16_BOM_EN
      bomPending_q <= 1'b1;
`endif
    end else begin
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      replaced_q <= replaced_d;
`ifdef UTF16_BOM_EN
      bomPending_q <= bomPending_d;
`endif
    end
  end

endmodule

// File: tb/tb_utf16_byte_serializer.sv
// Directed self-checking bench for utf16_byte_serializer.
// Expectations follow UTF16_BOM_EN when that macro is defined.
module tb_utf16_byte_serializer;

`ifdef UTF16_BOM_EN
  localparam bit BOM_EN = 1'b1;
`else
  localparam bit BOM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] cp_in;
  logic        cp_valid;
  logic        cp_ready;
  logic        little_endian;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        replaced;
  logic        busy;

  int  checks = 0;
  int  errors = 0;
  bit  bomPending = 1'b1;

  utf16_byte_serializer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cp_in         (cp_in),
    .cp_valid      (cp_valid),
    .cp_ready      (cp_ready),
    .little_endian (little_endian),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .replaced      (replaced),
    .busy          (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one code point at a falling edge; it must be taken at the next rising edge
  task automatic applyStimulus(input logic [20:0] cp, input logic le);
    cp_in         = cp;
    little_endian = le;
    cp_valid      = 1'b1;
    checkOutput("accept_ready", 32'(cp_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cp_valid = 1'b0;
  endtask

  // Prefix the byte-order mark to the expected bytes for the first character after reset
  task automatic addBom(input logic le, inout int n, inout logic [47:0] exp);
    if (BOM_EN && bomPending) begin
      exp        = {(le ? 16'hFFFE : 16'hFEFF), exp[47:16]};
      n          = n + 2;
      bomPending = 1'b0;
    end
  endtask

  // Check n consecutive bytes (first byte in exp[47:40]), one per cycle with byte_ready high;
  // optionally offer the next code point alongside the final byte
  task automatic expectBytes(input string tag, input int n, input logic [47:0] exp, input logic expRepl,
                             input logic chain, input logic [20:0] chainCp, input logic chainLe);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_valid"}, 32'(byte_valid), 32'd1);
      checkOutput({tag, "_byte"}, 32'(byte_out), 32'(exp[47-8*i -: 8]));
      if (i == 0) checkOutput({tag, "_replaced"}, 32'(replaced), 32'(expRepl));
      if (i == 1) checkOutput({tag, "_replaced_end"}, 32'(replaced), 32'd0);
      if (i == n - 1) begin
        checkOutput({tag, "_ready_last"}, 32'(cp_ready), 32'd1);
        if (chain) begin
          cp_in         = chainCp;
          little_endian = chainLe;
          cp_valid      = 1'b1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cp_valid = 1'b0;
    end
  endtask

  // One character end to end, then confirm the block went idle
  task automatic runChar(input string tag, input logic [20:0] cp, input logic le,
                         input int n, input logic [47:0] exp, input logic expRepl);
    int          nb;
    logic [47:0] eb;
    nb = n;
    eb = exp;
    addBom(le, nb, eb);
    applyStimulus(cp, le);
    expectBytes(tag, nb, eb, expRepl, 1'b0, 21'h0, 1'b0);
    checkOutput({tag, "_idle_valid"}, 32'(byte_valid), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          nb;
    logic [47:0] eb;

    rst_n         = 1'b0;
    cp_in         = 21'h0;
    cp_valid      = 1'b0;
    little_endian = 1'b0;
    byte_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_byte_out", 32'(byte_out), 32'h00);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("rst_cp_ready", 32'(cp_ready), 32'd1);
    checkOutput("rst_replaced", 32'(replaced), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] BMP character, big-endian");
    runChar("bmp_e9", 21'h0000E9, 1'b0, 2, {16'h00E9, 32'h0}, 1'b0);

    $display("[TB] Supplementary BE then LE back-to-back");
    nb = 4;
    eb = {32'hD83DDE00, 16'h0};
    applyStimulus(21'h01F600, 1'b0);
    expectBytes("supp_be", nb, eb, 1'b0, 1'b1, 21'h01F600, 1'b1);
    expectBytes("supp_le", 4, {32'h3DD800DE, 16'h0}, 1'b0, 1'b0, 21'h0, 1'b0);
    checkOutput("supp_idle", 32'(byte_valid), 32'd0);

    $display("[TB] Replacement and range boundaries");
    runChar("repl_d800", 21'h00D800, 1'b0, 2, {16'hFFFD, 32'h0}, 1'b1);
    runChar("repl_110000", 21'h110000, 1'b1, 2, {16'hFDFF, 32'h0}, 1'b1);
    runChar("repl_dfff", 21'h00DFFF, 1'b0, 2, {16'hFFFD, 32'h0}, 1'b1);
    runChar("legal_e000", 21'h00E000, 1'b0, 2, {16'hE000, 32'h0}, 1'b0);
    runChar("legal_ffff", 21'h00FFFF, 1'b1, 2, {16'hFFFF, 32'h0}, 1'b0);
    runChar("max_cp", 21'h10FFFF, 1'b0, 4, {32'hDBFFDFFF, 16'h0}, 1'b0);
    runChar("supp_base", 21'h010000, 1'b1, 4, {32'h00D800DC, 16'h0}, 1'b0);

    $display("[TB] Backpressure");
    applyStimulus(21'h01F600, 1'b0);
    checkOutput("bp_first", 32'(byte_out), 32'hD8);
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cp_in    = 21'h000041;
      cp_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_hold_byte", 32'(byte_out), 32'hD8);
      checkOutput("bp_hold_valid", 32'(byte_valid), 32'd1);
      checkOutput("bp_hold_ready", 32'(cp_ready), 32'd0);
    end
    cp_valid   = 1'b0;
    byte_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expectBytes("bp_resume", 3, {24'h3DDE00, 24'h0}, 1'b0, 1'b0, 21'h0, 1'b0);
    checkOutput("bp_idle", 32'(busy), 32'd0);

    $display("[TB] Reset during a character");
    applyStimulus(21'h01F600, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_second_byte", 32'(byte_out), 32'h3D);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(byte_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_byte", 32'(byte_out), 32'h00);
    checkOutput("mid_rst_ready", 32'(cp_ready), 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    bomPending = 1'b1;
    @(negedge clk);
    runChar("post_rst_41", 21'h000041, 1'b0, 2, {16'h0041, 32'h0}, 1'b0);
    runChar("post_rst_42", 21'h000042, 1'b1, 2, {16'h4200, 32'h0}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
